matrix_frame_scheduler: RTL and testbench

// Frame/line scheduler for the 3x3 matrix window path. Watches CMOS-style

---
 rtl/matrix_sched_pkg.sv | 14 +
 rtl/frame_sync_edge.sv | 34 +++
 rtl/matrix_frame_scheduler.sv | 151 +++++++++++++++
 tb/tb_matrix_frame_scheduler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_sched_pkg.sv
// Shared types and constants for the 3x3 matrix frame/line scheduler.
package matrix_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LINE = 2'd2,
        DONE = 2'd3
    } sched_state_t;

    localparam int unsigned CNT_W_DEF = 10;
    localparam int unsigned WIN_MIN   = 2;

endpackage

// File: rtl/frame_sync_edge.sv
// Registers vsync/href and flags vsync-active rise and href rise/fall edges.
module frame_sync_edge #(
    parameter logic VSYNC_VALID = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    input  logic href,
    output logic vs_rise,
    output logic href_rise,
    output logic href_fall
);

    logic vs_act;
    logic vs_act_d;
    logic href_d;

    assign vs_act = (vsync == VSYNC_VALID);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_act_d <= 1'b0;
            href_d   <= 1'b0;
        end else begin
            vs_act_d <= vs_act;
            href_d   <= href;
        end
    end

    assign vs_rise   = vs_act && !vs_act_d;
    assign href_rise = href && !href_d;
    assign href_fall = !href && href_d;

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Frame/line scheduler: tracks pixel position from vsync/href and drives
// line-buffer shift and 3x3 window-valid strobes, recovering from bad timing.
module matrix_frame_scheduler
    import matrix_sched_pkg::*;
#(
    parameter int unsigned IMG_HDISP   = 16,
    parameter int unsigned IMG_VDISP   = 5,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter logic        VSYNC_VALID = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    output logic             lb_shift_en,
    output logic             win_valid,
    output logic [CNT_W-1:0] col_idx,
    output logic [CNT_W-1:0] row_idx,
    output logic             frame_start,
    output logic             frame_done,
    output logic             err_pulse,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HMAX = CNT_W'(IMG_HDISP);
    localparam logic [CNT_W-1:0] VMAX = CNT_W'(IMG_VDISP);
    localparam logic [CNT_W-1:0] WMIN = CNT_W'(WIN_MIN);

    logic vs_rise;
    logic href_rise;
    logic href_fall;

    frame_sync_edge #(
        .VSYNC_VALID (VSYNC_VALID)
    ) u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .vsync     (per_frame_vsync),
        .href      (per_frame_href),
        .vs_rise   (vs_rise),
        .href_rise (href_rise),
        .href_fall (href_fall)
    );

    sched_state_t     state;
    logic [CNT_W-1:0] col_cnt;
    logic             long_err;
    logic [CNT_W-1:0] row_inc;
    logic             line_last;
    logic             pix_ok;
    logic             restart;

    assign row_inc   = row_idx + CNT_W'(1);
    assign line_last = (row_inc == VMAX);
    assign pix_ok    = (col_cnt < HMAX);
    // vs_rise mid-frame aborts it, unless the same cycle closed the last line
    assign restart   = vs_rise &&
                       ((state == WAIT) ||
                        ((state == LINE) && !(href_fall && line_last)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            col_cnt     <= '0;
            long_err    <= 1'b0;
            lb_shift_en <= 1'b0;
            win_valid   <= 1'b0;
            col_idx     <= '0;
            row_idx     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            lb_shift_en <= 1'b0;
            win_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_pulse   <= 1'b0;

            case (state)
                IDLE: begin
                    if (vs_rise && enable) begin
                        state       <= WAIT;
                        frame_start <= 1'b1;
                        busy        <= 1'b1;
                        row_idx     <= '0;
                        col_idx     <= '0;
                    end
                end
                WAIT: begin
                    // The href rise cycle already carries pixel 0
                    if (href_rise) begin
                        state       <= LINE;
                        lb_shift_en <= 1'b1;
                        col_idx     <= '0;
                        col_cnt     <= CNT_W'(1);
                        long_err    <= 1'b0;
                    end
                end
                LINE: begin
                    if (href_fall) begin
                        if (col_cnt < HMAX) begin
                            err_pulse <= 1'b1;
                        end
                        if (line_last) begin
                            state <= DONE;
                        end else begin
                            row_idx <= row_inc;
                            state   <= WAIT;
                        end
                    end else if (pix_ok) begin
                        lb_shift_en <= 1'b1;
                        col_idx     <= col_cnt;
                        col_cnt     <= col_cnt + CNT_W'(1);
                        win_valid   <= (row_idx >= WMIN) && (col_cnt >= WMIN);
                    end else if (!long_err) begin
                        err_pulse <= 1'b1;
                        long_err  <= 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    row_idx    <= '0;
                    col_idx    <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (restart) begin
                err_pulse   <= 1'b1;
                lb_shift_en <= 1'b0;
                win_valid   <= 1'b0;
                row_idx     <= '0;
                col_idx     <= '0;
                if (enable) begin
                    state       <= WAIT;
                    frame_start <= 1'b1;
                    busy        <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Scoreboard bench for matrix_frame_scheduler (16x5 frame, vsync active high).
module tb_matrix_frame_scheduler;

    localparam int unsigned HD = 16;
    localparam int unsigned VD = 5;
    localparam int unsigned CW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          vsync;
    logic          href;
    logic          lb_shift_en;
    logic          win_valid;
    logic [CW-1:0] col_idx;
    logic [CW-1:0] row_idx;
    logic          frame_start;
    logic          frame_done;
    logic          err_pulse;
    logic          busy;

    int vectors    = 0;
    int miscompares = 0;

    int n_start = 0;
    int n_done  = 0;
    int n_err   = 0;
    int n_shift = 0;
    int n_win   = 0;

    logic [31:0] exp_q[$];

    matrix_frame_scheduler #(
        .IMG_HDISP   (HD),
        .IMG_VDISP   (VD),
        .CNT_W       (CW),
        .VSYNC_VALID (1'b1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .per_frame_vsync (vsync),
        .per_frame_href  (href),
        .lb_shift_en     (lb_shift_en),
        .win_valid       (win_valid),
        .col_idx         (col_idx),
        .row_idx         (row_idx),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .err_pulse       (err_pulse),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pix_word(input int unsigned c, input int unsigned r, input logic w);
        return {11'd0, 10'(c), 10'(r), w};
    endfunction

    // Monitor: count pulses, pop the scoreboard on every shifted pixel
    always @(negedge clk) begin
        if (rst_n) begin
            n_start += int'(frame_start);
            n_done  += int'(frame_done);
            n_err   += int'(err_pulse);
            n_shift += int'(lb_shift_en);
            n_win   += int'(win_valid);
            if (lb_shift_en) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_shift", 32'(col_idx), 32'hFFFF);
                end else begin
                    chk("pixel", pix_word(int'(col_idx), int'(row_idx), win_valid), exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(2);
    endtask

    // Drive one href line; push expectations only if the frame is live
    task automatic drive_line(input int npix, input int row, input bit live);
        for (int i = 0; i < npix; i++) begin
            href = 1'b1;
            if (live && i < int'(HD))
                exp_q.push_back(pix_word(i, row, (row >= 2) && (i >= 2)));
            tick(1);
            if (live && i >= int'(HD)) begin
                chk("long_col_hold", 32'(col_idx), 32'(HD - 1));
                chk("long_no_shift", 32'(lb_shift_en), 32'd0);
            end
        end
        href = 1'b0;
        tick(3);
        chk("q_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic full_frame(input bit live);
        vsync_pulse();
        for (int r = 0; r < int'(VD); r++) drive_line(HD, r, live);
    endtask

    int s0, d0, e0, sh0, w0;

    task automatic snap();
        s0 = n_start; d0 = n_done; e0 = n_err; sh0 = n_shift; w0 = n_win;
    endtask

    task automatic chk_counts(input string tag, input int s, input int d, input int e, input int sh);
        chk({tag, "_start"}, 32'(n_start - s0), 32'(s));
        chk({tag, "_done"},  32'(n_done - d0),  32'(d));
        chk({tag, "_err"},   32'(n_err - e0),   32'(e));
        chk({tag, "_shift"}, 32'(n_shift - sh0), 32'(sh));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; href = 1'b0;
        tick(3);
        chk("rst_outs", {21'd0, lb_shift_en, win_valid, frame_start, frame_done, err_pulse, busy, 5'd0}, 32'd0);
        chk("rst_idx", {12'd0, col_idx, row_idx}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // 1 nominal frame
        enable = 1'b1;
        snap();
        vsync_pulse();
        chk("t1_busy", 32'(busy), 32'd1);
        for (int r = 0; r < int'(VD); r++) drive_line(HD, r, 1'b1);
        chk_counts("t1", 1, 1, 0, 80);
        chk("t1_win", 32'(n_win - w0), 32'd42);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2 short line on row 2
        snap();
        vsync_pulse();
        for (int r = 0; r < int'(VD); r++) drive_line((r == 2) ? 12 : HD, r, 1'b1);
        chk_counts("t2", 1, 1, 1, 76);
        chk("t2_win", 32'(n_win - w0), 32'd38);

        // 3 long line on row 0
        snap();
        vsync_pulse();
        for (int r = 0; r < int'(VD); r++) drive_line((r == 0) ? 20 : HD, r, 1'b1);
        chk_counts("t3", 1, 1, 1, 80);

        // 4 early vsync after 3 lines, then clean frame
        snap();
        vsync_pulse();
        for (int r = 0; r < 3; r++) drive_line(HD, r, 1'b1);
        vsync_pulse();
        chk("t4_busy", 32'(busy), 32'd1);
        chk("t4_no_done", 32'(n_done - d0), 32'd0);
        for (int r = 0; r < int'(VD); r++) drive_line(HD, r, 1'b1);
        chk_counts("t4", 2, 1, 1, 128);

        // 5a enable low at vsync: frame ignored
        enable = 1'b0;
        snap();
        vsync_pulse();
        chk("t5a_busy", 32'(busy), 32'd0);
        for (int r = 0; r < int'(VD); r++) drive_line(HD, r, 1'b0);
        chk_counts("t5a", 0, 0, 0, 0);

        // 5b enable dropped mid-frame: finishes, next frame ignored
        enable = 1'b1;
        snap();
        vsync_pulse();
        drive_line(HD, 0, 1'b1);
        enable = 1'b0;
        for (int r = 1; r < int'(VD); r++) drive_line(HD, r, 1'b1);
        full_frame(1'b0);
        chk_counts("t5b", 1, 1, 0, 80);

        // 6 reset mid-line, then a clean frame
        enable = 1'b1;
        vsync_pulse();
        drive_line(HD, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            href = 1'b1;
            exp_q.push_back(pix_word(i, 1, 1'b0));
            tick(1);
        end
        rst_n = 1'b0;
        tick(2);
        chk("t6_rst_outs", {26'd0, lb_shift_en, win_valid, frame_start, frame_done, err_pulse, busy}, 32'd0);
        chk("t6_rst_idx", {12'd0, col_idx, row_idx}, 32'd0);
        href = 1'b0;
        rst_n = 1'b1;
        exp_q.delete();
        tick(2);
        snap();
        full_frame(1'b1);
        chk_counts("t6", 1, 1, 0, 80);

        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
